// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture: oversamples the OV7670 parallel bus in the clk50 domain,
// packs byte pairs into RGB565 pixels and writes them once each to a linear
// frame-buffer address (y*H_RES + x). Flags frame completion and short lines.
//
// Handshake: the write side has no back-pressure. pix_we is a one-cycle
// strobe; pix_data and pix_addr are valid only in the cycle where pix_we=1.
// frame_done is a one-cycle pulse after the closing VSYNC rise of a captured frame.
module cam_pixel_capture #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic              en,
  input  logic              PCLK_cam,
  input  logic              HREF_cam,
  input  logic              VSYNC_cam,
  input  logic [7:0]        data_cam,
  output logic [15:0]       pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_we,
  output logic              frame_done,
  output logic              busy,
  output logic              line_err,
  output logic [1:0]        o_dbg_state
);

  // Counter widths are chosen so x and y can hold H_RES / V_RES themselves,
  // which is the saturation value.
  localparam int XW = $clog2(H_RES + 1);
  localparam int YW = $clog2(V_RES + 1);

  localparam logic [XW-1:0]     X_MAX     = XW'(H_RES);
  localparam logic [YW-1:0]     Y_MAX     = YW'(V_RES);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(H_RES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  // Synchronizer chains (s1 -> s2) plus one history flop (h) per control pin.
  logic        r_pclk_s1, r_pclk_s2, r_pclk_h;
  logic        r_href_s1, r_href_s2, r_href_h;
  logic        r_vs_s1,   r_vs_s2,   r_vs_h;
  logic [7:0]  r_data_s1, r_data_s2;

  // FSM state.
  state_t      r_state, w_state_nxt;

  // Datapath registers.
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic              r_phase;
  logic [7:0]        r_hi;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_row_base;
  logic [15:0]       r_pix_data;
  logic [ADDR_W-1:0] r_pix_addr;
  logic              r_we;
  logic              r_frame_done;
  logic              r_line_err;

  // Edge events on the synchronized signals.
  logic w_pclk_rise;
  logic w_vs_fall;
  logic w_vs_rise;
  logic w_href_fall;

  // Control strobes decoded by the FSM for the datapath.
  logic w_arm;
  logic w_start;
  logic w_frame_end;
  logic w_line_end;
  logic w_byte;

  // Synchronize the camera pins; data uses the same depth as PCLK so the
  // byte seen on a detected PCLK rise is the one present at the pin edge.
  always_ff @(posedge clk50) begin
    if (!rst) begin
      r_pclk_s1 <= 1'b0;
      r_pclk_s2 <= 1'b0;
      r_pclk_h  <= 1'b0;
      r_href_s1 <= 1'b0;
      r_href_s2 <= 1'b0;
      r_href_h  <= 1'b0;
      r_vs_s1   <= 1'b0;
      r_vs_s2   <= 1'b0;
      r_vs_h    <= 1'b0;
      r_data_s1 <= 8'h00;
      r_data_s2 <= 8'h00;
    end else begin
      r_pclk_s1 <= PCLK_cam;
      r_pclk_s2 <= r_pclk_s1;
      r_pclk_h  <= r_pclk_s2;
      r_href_s1 <= HREF_cam;
      r_href_s2 <= r_href_s1;
      r_href_h  <= r_href_s2;
      r_vs_s1   <= VSYNC_cam;
      r_vs_s2   <= r_vs_s1;
      r_vs_h    <= r_vs_s2;
      r_data_s1 <= data_cam;
      r_data_s2 <= r_data_s1;
    end
  end

  assign w_pclk_rise = r_pclk_s2 & ~r_pclk_h;
  assign w_vs_fall   = ~r_vs_s2  &  r_vs_h;
  assign w_vs_rise   = r_vs_s2   & ~r_vs_h;
  assign w_href_fall = ~r_href_s2 & r_href_h;

  // FSM state register.
  always_ff @(posedge clk50) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and strobe decode. Inside CAPTURE the event priority is
  // vs_rise over href_fall over pclk_rise; only one strobe fires per cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_start     = 1'b0;
    w_frame_end = 1'b0;
    w_line_end  = 1'b0;
    w_byte      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_arm       = 1'b1;
          w_state_nxt = S_WAIT_VS;
        end
      end
      S_WAIT_VS: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
        end else if (w_vs_fall) begin
          w_start     = 1'b1;
          w_state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (w_vs_rise) begin
          w_frame_end = 1'b1;
          w_state_nxt = en ? S_WAIT_VS : S_IDLE;
        end else if (w_href_fall) begin
          w_line_end = 1'b1;
        end else if (w_pclk_rise && r_href_s2) begin
          w_byte = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Pixel packing, counters, linear address and status flags.
  always_ff @(posedge clk50) begin
    if (!rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_phase      <= 1'b0;
      r_hi         <= 8'h00;
      r_addr       <= '0;
      r_row_base   <= '0;
      r_pix_data   <= 16'h0000;
      r_pix_addr   <= '0;
      r_we         <= 1'b0;
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
    end else begin
      r_we         <= 1'b0;
      r_frame_done <= w_frame_end;

      if (w_arm) begin
        r_line_err <= 1'b0;
      end

      if (w_start) begin
        r_x        <= '0;
        r_y        <= '0;
        r_phase    <= 1'b0;
        r_addr     <= '0;
        r_row_base <= '0;
      end

      // End of line: drop any odd byte, flag a short line and move the
      // address to the start of the next row so rows stay aligned.
      if (w_line_end) begin
        r_x     <= '0;
        r_phase <= 1'b0;
        if (r_x < X_MAX) begin
          r_line_err <= 1'b1;
        end
        if (r_y < Y_MAX) begin
          r_y        <= r_y + YW'(1);
          r_row_base <= r_row_base + ADDR_STEP;
          r_addr     <= r_row_base + ADDR_STEP;
        end
      end

      // Byte handling: phase 0 holds the high byte, phase 1 completes the
      // pixel. Out-of-window pixels advance nothing but the saturating x.
      if (w_byte) begin
        if (!r_phase) begin
          r_hi    <= r_data_s2;
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          if ((r_x < X_MAX) && (r_y < Y_MAX)) begin
            r_we       <= 1'b1;
            r_pix_data <= {r_hi, r_data_s2};
            r_pix_addr <= r_addr;
            r_addr     <= r_addr + ADDR_W'(1);
          end
          if (r_x < X_MAX) begin
            r_x <= r_x + XW'(1);
          end
        end
      end
    end
  end

  assign pix_data    = r_pix_data;
  assign pix_addr    = r_pix_addr;
  assign pix_we      = r_we;
  assign frame_done  = r_frame_done;
  assign line_err    = r_line_err;
  assign busy        = (r_state == S_WAIT_VS) || (r_state == S_CAPTURE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Testbench for cam_pixel_capture with a small 4x2 frame: table of frame
// shapes with hand-computed outcomes plus directed reset/arming sequences.
// A write monitor compares every pix_we against an expected queue.
module tb_cam_pixel_capture;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 17;

  // ---------------- clock / reset / DUT ----------------
  logic          clk50 = 1'b0;
  logic          rst;
  logic          en;
  logic          PCLK_cam;
  logic          HREF_cam;
  logic          VSYNC_cam;
  logic [7:0]    data_cam;
  logic [15:0]   pix_data;
  logic [AW-1:0] pix_addr;
  logic          pix_we;
  logic          frame_done;
  logic          busy;
  logic          line_err;
  logic [1:0]    o_dbg_state;

  always #10 clk50 = ~clk50;

  cam_pixel_capture #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .clk50       (clk50),
    .rst         (rst),
    .en          (en),
    .PCLK_cam    (PCLK_cam),
    .HREF_cam    (HREF_cam),
    .VSYNC_cam   (VSYNC_cam),
    .data_cam    (data_cam),
    .pix_data    (pix_data),
    .pix_addr    (pix_addr),
    .pix_we      (pix_we),
    .frame_done  (frame_done),
    .busy        (busy),
    .line_err    (line_err),
    .o_dbg_state (o_dbg_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [15:0]   exp_data_q[$];

  int          n_writes;
  int          fd_cnt;
  int          max_addr;
  logic [15:0] first_data;
  logic        first_seen;
  logic        prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    n_writes   = 0;
    fd_cnt     = 0;
    max_addr   = 0;
    first_data = 16'h0;
    first_seen = 1'b0;
  endtask

  // Write monitor, sampled on the inactive clock edge.
  always @(negedge clk50) begin
    if (pix_we === 1'b1) begin
      n_writes++;
      if (int'(pix_addr) > max_addr) max_addr = int'(pix_addr);
      if (!first_seen) begin
        first_seen = 1'b1;
        first_data = pix_data;
      end
      check("we_pulse_width", 32'(prev_we), 32'd0);
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%04h, expected no write", pix_addr, pix_data);
      end else begin
        check("write_addr", 32'(pix_addr), 32'(exp_addr_q.pop_front()));
        check("write_data", 32'(pix_data), 32'(exp_data_q.pop_front()));
      end
    end
    if (frame_done === 1'b1) fd_cnt++;
    prev_we = pix_we;
  end

  // ---------------- camera model / drivers ----------------
  int          m_y;
  int          m_j;
  int          m_k;
  logic        m_active;
  logic [7:0]  m_prev;

  task automatic tick(input int n);
    repeat (n) @(negedge clk50);
  endtask

  function automatic logic [7:0] byte_of(input int k);
    logic [7:0] kk;
    kk = 8'(k);
    return 8'h12 + kk * 8'h22;
  endfunction

  task automatic send_byte();
    logic [7:0] b;
    b = byte_of(m_k);
    m_k++;
    PCLK_cam = 1'b0;
    data_cam = b;
    tick(2);
    if (m_active && (m_j % 2 == 1) && (m_j / 2 < H) && (m_y < V)) begin
      exp_addr_q.push_back(AW'(m_y * H + m_j / 2));
      exp_data_q.push_back({m_prev, b});
    end
    m_prev = b;
    m_j++;
    PCLK_cam = 1'b1;
    tick(2);
  endtask

  task automatic line_begin();
    HREF_cam = 1'b1;
    m_j = 0;
    tick(2);
  endtask

  task automatic line_end();
    PCLK_cam = 1'b0;
    tick(3);
    HREF_cam = 1'b0;
    tick(6);
    if (m_active && m_y < V) m_y++;
  endtask

  task automatic send_line(input int len);
    line_begin();
    for (int j = 0; j < len; j++) send_byte();
    line_end();
  endtask

  task automatic vs_start();
    VSYNC_cam = 1'b0;
    m_y = 0;
    m_k = 0;
    tick(6);
  endtask

  task automatic vs_end();
    PCLK_cam  = 1'b0;
    VSYNC_cam = 1'b1;
    tick(8);
  endtask

  // ---------------- frame-shape table ----------------
  typedef struct {
    string       name;
    int          nlines;
    int          len0;
    int          len1;
    int          len2;
    int          exp_writes;
    int          exp_max;
    logic        exp_err;
    logic [15:0] exp_first;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{"nominal",     2, 8,  8,  0,  8, 7, 1'b0, 16'h1234};
    vecs[1] = '{"short_odd",   2, 5,  8,  0,  6, 7, 1'b1, 16'h1234};
    vecs[2] = '{"overlong",    3, 10, 10, 10, 8, 7, 1'b0, 16'h1234};
    vecs[3] = '{"short_last",  2, 8,  2,  0,  5, 4, 1'b1, 16'h1234};
    vecs[4] = '{"odd_full",    2, 9,  8,  0,  8, 7, 1'b0, 16'h1234};

    rst       = 1'b0;
    en        = 1'b0;
    PCLK_cam  = 1'b0;
    HREF_cam  = 1'b0;
    VSYNC_cam = 1'b1;
    data_cam  = 8'h00;
    m_active  = 1'b0;
    m_y = 0; m_j = 0; m_k = 0; m_prev = 8'h00;
    clear_stats();

    // Reset with random bus activity.
    for (int i = 0; i < 12; i++) begin
      PCLK_cam  = 1'($urandom_range(0, 1));
      HREF_cam  = 1'($urandom_range(0, 1));
      VSYNC_cam = 1'($urandom_range(0, 1));
      data_cam  = 8'($urandom_range(0, 255));
      en        = 1'($urandom_range(0, 1));
      tick(1);
    end
    check("rst_pix_we",     32'(pix_we),      32'd0);
    check("rst_frame_done", 32'(frame_done),  32'd0);
    check("rst_busy",       32'(busy),        32'd0);
    check("rst_line_err",   32'(line_err),    32'd0);
    check("rst_pix_data",   32'(pix_data),    32'd0);
    check("rst_pix_addr",   32'(pix_addr),    32'd0);
    check("rst_state",      32'(o_dbg_state), 32'd0);

    // Released with en=0: must stay idle despite bus activity.
    rst = 1'b1;
    en  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      PCLK_cam  = 1'($urandom_range(0, 1));
      HREF_cam  = 1'($urandom_range(0, 1));
      VSYNC_cam = 1'($urandom_range(0, 1));
      data_cam  = 8'($urandom_range(0, 255));
      tick(1);
    end
    check("idle_busy",  32'(busy),        32'd0);
    check("idle_state", 32'(o_dbg_state), 32'd0);
    PCLK_cam = 1'b0; HREF_cam = 1'b0; VSYNC_cam = 1'b1; data_cam = 8'h00;
    tick(8);

    // Table-driven frames: arm from IDLE, capture, drop en mid-frame.
    for (int v = 0; v < 5; v++) begin
      clear_stats();
      en = 1'b1;
      tick(2);
      check({vecs[v].name, "_arm_busy"},     32'(busy),     32'd1);
      check({vecs[v].name, "_arm_clr_err"},  32'(line_err), 32'd0);
      m_active = 1'b1;
      vs_start();
      for (int l = 0; l < vecs[v].nlines; l++) begin
        send_line(l == 0 ? vecs[v].len0 : (l == 1 ? vecs[v].len1 : vecs[v].len2));
      end
      en = 1'b0;
      tick(2);
      check({vecs[v].name, "_busy_hold"},  32'(busy),        32'd1);
      vs_end();
      m_active = 1'b0;
      check({vecs[v].name, "_writes"},     32'(n_writes),    32'(vecs[v].exp_writes));
      check({vecs[v].name, "_max_addr"},   32'(max_addr),    32'(vecs[v].exp_max));
      check({vecs[v].name, "_first_data"}, 32'(first_data),  32'(vecs[v].exp_first));
      check({vecs[v].name, "_frame_done"}, 32'(fd_cnt),      32'd1);
      check({vecs[v].name, "_line_err"},   32'(line_err),    32'(vecs[v].exp_err));
      check({vecs[v].name, "_end_busy"},   32'(busy),        32'd0);
      check({vecs[v].name, "_end_state"},  32'(o_dbg_state), 32'd0);
      check({vecs[v].name, "_queue_left"}, 32'(exp_addr_q.size()), 32'd0);
    end

    // Arming mid-frame: nothing is written until the next vs_fall.
    clear_stats();
    vs_start();
    send_line(8);
    en = 1'b1;
    tick(2);
    check("midarm_busy", 32'(busy), 32'd1);
    send_line(8);
    vs_end();
    check("midarm_no_writes", 32'(n_writes), 32'd0);
    check("midarm_no_done",   32'(fd_cnt),   32'd0);
    m_active = 1'b1;
    vs_start();
    send_line(8);
    send_line(8);
    vs_end();
    m_active = 1'b0;
    check("midarm_writes",   32'(n_writes), 32'd8);
    check("midarm_done",     32'(fd_cnt),   32'd1);
    check("midarm_rearmed",  32'(busy),     32'd1);
    en = 1'b0;
    tick(2);
    check("midarm_disarm",   32'(busy),     32'd0);

    // Reset in the middle of a line after three pixels.
    clear_stats();
    en = 1'b1;
    tick(2);
    m_active = 1'b1;
    vs_start();
    line_begin();
    for (int j = 0; j < 6; j++) send_byte();
    PCLK_cam = 1'b0;
    tick(4);
    check("midrst_pre_writes", 32'(n_writes), 32'd3);
    m_active = 1'b0;
    rst = 1'b0;
    tick(1);
    check("midrst_we",    32'(pix_we),      32'd0);
    check("midrst_addr",  32'(pix_addr),    32'd0);
    check("midrst_busy",  32'(busy),        32'd0);
    check("midrst_state", 32'(o_dbg_state), 32'd0);
    rst = 1'b1;
    for (int j = 0; j < 4; j++) send_byte();
    line_end();
    send_line(8);
    vs_end();
    check("midrst_post_writes", 32'(n_writes), 32'd3);
    check("midrst_no_done",     32'(fd_cnt),   32'd0);
    clear_stats();
    m_active = 1'b1;
    vs_start();
    send_line(8);
    send_line(8);
    en = 1'b0;
    vs_end();
    m_active = 1'b0;
    check("midrst_next_writes", 32'(n_writes), 32'd8);
    check("midrst_next_done",   32'(fd_cnt),   32'd1);
    check("midrst_next_err",    32'(line_err), 32'd0);

    tick(4);
    check("final_queue_left", 32'(exp_addr_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
